// File: rtl/read_word_unit_if.sv
// Read word unit bus bundle.
// Groups the CPU request/response handshake, SRAM read port, tag hit input
// and refill request/response signals. clk and reset stay plain module ports.
//   slave  : the read word unit side
//   master : the environment side (CPU, SRAM, tag compare, refill engine)
interface read_word_unit_if #(
    parameter int unsigned INDEX_W = 6
);
    logic                 cpu_req_valid;
    logic                 cpu_req_ready;
    logic [31:0]          cpu_req_addr;
    logic                 sram_rd_en;
    logic [INDEX_W-1:0]   sram_rd_addr;
    logic [127:0]         sram_rd_data;
    logic                 hit;
    logic                 miss_req;
    logic                 mem_resp_valid;
    logic [127:0]         mem_resp_data;
    logic                 cpu_resp_valid;
    logic                 cpu_resp_ready;
    logic [31:0]          cpu_resp_data;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, sram_rd_data, hit,
               mem_resp_valid, mem_resp_data, cpu_resp_ready,
        output cpu_req_ready, sram_rd_en, sram_rd_addr, miss_req,
               cpu_resp_valid, cpu_resp_data
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, sram_rd_data, hit,
               mem_resp_valid, mem_resp_data, cpu_resp_ready,
        input  cpu_req_ready, sram_rd_en, sram_rd_addr, miss_req,
               cpu_resp_valid, cpu_resp_data
    );
endinterface

// File: rtl/read_word_unit.sv
// Read word unit: looks up one 32-bit word of a 128-bit cache line.
// IDLE accepts a request and issues the SRAM read in the same cycle, LOOKUP
// consumes SRAM data plus hit, REFILL waits for the refill line, RESP holds
// the registered word until the CPU takes it.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - read_word_unit_if.slave (CPU req/resp, SRAM read, hit, refill)
// Configuration macro REFILL_FWD_EN:
//   defined   - the requested word is forwarded from the refill line
//   undefined - the line is re-read from SRAM after the refill (default)
module read_word_unit #(
    parameter int unsigned INDEX_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    read_word_unit_if.slave bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [1:0]          word_q, word_d;
    logic [WORD_W-1:0]   data_q, data_d;
    // First LOOKUP cycle after a refill only re-issues the SRAM read.
    logic                reissue_q, reissue_d;

    // Pick word w out of a line (word 0 = bits [31:0]).
    function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        w);
        logic [WORD_W-1:0] r;
        case (w)
            2'd0:    r = line[31:0];
            2'd1:    r = line[63:32];
            2'd2:    r = line[95:64];
            default: r = line[127:96];
        endcase
        return r;
    endfunction

    // Address bits outside word select and index are not needed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_req_addr[31:INDEX_W+4], bus.cpu_req_addr[1:0]};
`ifndef REFILL_FWD_EN
    logic unused_mem_data;
    assign unused_mem_data = ^bus.mem_resp_data;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            word_q    <= '0;
            data_q    <= '0;
            reissue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            word_q    <= word_d;
            data_q    <= data_d;
            reissue_q <= reissue_d;
        end
    end

    assign bus.cpu_resp_data = data_q;

    // Next state and handshake/strobe outputs.
    always_comb begin
        state_d            = state_q;
        index_d            = index_q;
        word_d             = word_q;
        data_d             = data_q;
        reissue_d          = 1'b0;
        bus.cpu_req_ready  = 1'b0;
        bus.sram_rd_en     = 1'b0;
        bus.sram_rd_addr   = index_q;
        bus.miss_req       = 1'b0;
        bus.cpu_resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                bus.sram_rd_addr  = bus.cpu_req_addr[INDEX_W+3:4];
                if (bus.cpu_req_valid) begin
                    bus.sram_rd_en = 1'b1;
                    index_d        = bus.cpu_req_addr[INDEX_W+3:4];
                    word_d         = bus.cpu_req_addr[3:2];
                    state_d        = LOOKUP;
                end
            end
            LOOKUP: begin
                if (reissue_q) begin
                    bus.sram_rd_en = 1'b1;
                end else if (bus.hit) begin
                    data_d  = sel_word(bus.sram_rd_data, word_q);
                    state_d = RESP;
                end else begin
                    bus.miss_req = 1'b1;
                    state_d      = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_resp_valid) begin
`ifdef REFILL_FWD_EN
                    data_d    = sel_word(bus.mem_resp_data, word_q);
                    state_d   = RESP;
`else
                    reissue_d = 1'b1;
                    state_d   = LOOKUP;
`endif
                end
            end
            RESP: begin
                bus.cpu_resp_valid = 1'b1;
                if (bus.cpu_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet while reset is held.
        if (reset) begin
            bus.cpu_req_ready  = 1'b0;
            bus.sram_rd_en     = 1'b0;
            bus.sram_rd_addr   = '0;
            bus.miss_req       = 1'b0;
            bus.cpu_resp_valid = 1'b0;
        end
    end
endmodule
